// File: rtl/req_arbiter_if.sv
// -----------------------------------------------------------------------------
// req_arbiter_if
// Bundles the requester handshake and shared-resource signals of req_arbiter.
//
// Signals:
//   reqs       [REQ_NUMBER-1:0]  request lines, held high until acked
//   acks       [REQ_NUMBER-1:0]  one-hot grant/ack back to the requesters
//   start                        one-cycle pulse launching the shared resource
//   done                         finish pulse returned by the shared resource
//   grantIdx   [IDX_W-1:0]       index of the current or most recent grant
//   busy                         arbiter is not idle
//   timeoutErr                   one-cycle pulse when the watchdog aborts
//
// Modports:
//   slave  : the arbiter side (consumes reqs/done, produces the rest)
//   master : the environment side (requesters plus shared resource)
// -----------------------------------------------------------------------------
interface req_arbiter_if #(
  parameter int REQ_NUMBER = 4
);
  localparam int IDX_W = $clog2(REQ_NUMBER);

  logic [REQ_NUMBER-1:0] reqs;
  logic [REQ_NUMBER-1:0] acks;
  logic                  start;
  logic                  done;
  logic [IDX_W-1:0]      grantIdx;
  logic                  busy;
  logic                  timeoutErr;

  modport slave (
    input  reqs,
    input  done,
    output acks,
    output start,
    output grantIdx,
    output busy,
    output timeoutErr
  );

  modport master (
    output reqs,
    output done,
    input  acks,
    input  start,
    input  grantIdx,
    input  busy,
    input  timeoutErr
  );
endinterface

// File: rtl/req_arbiter.sv
// -----------------------------------------------------------------------------
// req_arbiter
// Round-robin arbiter sharing one start/done resource among REQ_NUMBER
// requesters using a 4-phase req/ack handshake, with an abort watchdog.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : req_arbiter_if.slave (reqs, done in; acks, start, grantIdx, busy,
//          timeoutErr out; all outputs registered)
//
// Parameters:
//   REQ_NUMBER : number of requesters (>= 2); must match the interface
//   TIMEOUT    : WAIT_DONE cycles before abort, 0 disables the watchdog
//   CNT_W      : watchdog counter width, TIMEOUT < 2**CNT_W
// -----------------------------------------------------------------------------
module req_arbiter #(
  parameter int REQ_NUMBER = 4,
  parameter int TIMEOUT    = 256,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  req_arbiter_if.slave     bus
);

  localparam int IDX_W = $clog2(REQ_NUMBER);
  localparam logic [REQ_NUMBER-1:0] ACK_LSB    = {{(REQ_NUMBER-1){1'b0}}, 1'b1};
  localparam logic [REQ_NUMBER-1:0] ACK_NONE   = {REQ_NUMBER{1'b0}};
  localparam logic [IDX_W-1:0]      PTR_RESET  = IDX_W'(REQ_NUMBER - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam bit                    TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [REQ_NUMBER-1:0] acks_q, acks_d;
  logic                  start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [IDX_W:0]        pick_s;
  logic                  pick_valid_s;
  logic [IDX_W-1:0]      pick_idx_s;

  // Round-robin search: returns {valid, index} of the first set request
  // starting at ptr+1 and wrapping. The loop walks from ptr itself (lowest
  // priority) towards ptr+1 (highest) so the last hit is the winner.
  function automatic logic [IDX_W:0] rr_pick(
    input logic [REQ_NUMBER-1:0] req,
    input logic [IDX_W-1:0]      ptr
  );
    logic [IDX_W:0]        res;
    logic [REQ_NUMBER-1:0] rot;
    int                    idx;
    res = {(IDX_W+1){1'b0}};
    for (int i = REQ_NUMBER; i >= 1; i--) begin
      idx = int'(ptr) + i;
      idx = (idx >= REQ_NUMBER) ? idx - REQ_NUMBER : idx;
      rot = req >> idx;
      res = rot[0] ? {1'b1, IDX_W'(idx)} : res;
    end
    return res;
  endfunction

  // Candidate winner for the next grant.
  always_comb begin
    pick_s       = rr_pick(bus.reqs, ptr_q);
    pick_valid_s = pick_s[IDX_W];
    pick_idx_s   = pick_s[IDX_W-1:0];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    acks_d        = acks_q;
    start_d       = 1'b0;
    busy_d        = busy_q;
    timeout_err_d = 1'b0;
    grant_idx_d   = grant_idx_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          state_d     = START;
          acks_d      = ACK_LSB << pick_idx_s;
          grant_idx_d = pick_idx_s;
          start_d     = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = {CNT_W{1'b0}};
        end else begin
          acks_d = ACK_NONE;
          busy_d = 1'b0;
        end
      end

      START: begin
        // A done arriving right after the start pulse is still accepted.
        if (bus.done) begin
          state_d = RELEASE;
        end else begin
          state_d = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        // done is checked first so it wins over a simultaneous timeout.
        if (bus.done) begin
          state_d = RELEASE;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          state_d       = RELEASE;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RELEASE: begin
        // acks_q is one-hot on the granted requester, so masking picks reqs[g].
        if ((bus.reqs & acks_q) == ACK_NONE) begin
          state_d = IDLE;
          acks_d  = ACK_NONE;
          busy_d  = 1'b0;
          ptr_d   = grant_idx_q;
        end else begin
          state_d = RELEASE;
        end
      end

      default: begin
        state_d = IDLE;
        acks_d  = ACK_NONE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      acks_q        <= ACK_NONE;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      grant_idx_q   <= {IDX_W{1'b0}};
      ptr_q         <= PTR_RESET;
      cnt_q         <= {CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      acks_q        <= acks_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      grant_idx_q   <= grant_idx_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.acks       = acks_q;
  assign bus.start      = start_q;
  assign bus.busy       = busy_q;
  assign bus.timeoutErr = timeout_err_q;
  assign bus.grantIdx   = grant_idx_q;

endmodule

// File: tb/tb_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_req_arbiter
// Self-checking bench for req_arbiter: directed scenarios followed by a
// randomized run against a transaction-level reference model.
// Inputs change 1 time unit after the rising edge; outputs are observed at
// that same point, i.e. after the edge that produced them.
// -----------------------------------------------------------------------------
module tb_req_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk;
  logic rst;

  req_arbiter_if #(.REQ_NUMBER(N)) bus ();

  req_arbiter #(.REQ_NUMBER(N), .TIMEOUT(TO), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Observed output vector: {acks[3:0], start, busy, grantIdx[1:0], timeoutErr}
  logic [8:0] obs;
  assign obs = {bus.acks, bus.start, bus.busy, bus.grantIdx, bus.timeoutErr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.reqs = 4'b0000; bus.done = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.reqs = 4'b1111; bus.done = 1'b1;
    cyc();
    checks++;
    if (obs !== 9'b0000_0_0_00_0) begin
      errors++; $display("FAIL reset_state: got %b expected %b", obs, 9'b0000_0_0_00_0);
    end
    rst = 1'b0; bus.reqs = 4'b0000; bus.done = 1'b0;
    cyc();
    checks++;
    if (obs !== 9'b0000_0_0_00_0) begin
      errors++; $display("FAIL reset_idle: got %b expected %b", obs, 9'b0000_0_0_00_0);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.reqs = 4'b0001;
    cyc();
    checks++;
    if (obs !== 9'b0001_1_1_00_0) begin
      errors++; $display("FAIL single_grant: got %b expected %b", obs, 9'b0001_1_1_00_0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (obs !== 9'b0001_0_1_00_0) begin
        errors++; $display("FAIL single_wait: cycle %0d got %b expected %b", i, obs, 9'b0001_0_1_00_0);
      end
    end
    bus.done = 1'b1;
    cyc();
    bus.done = 1'b0;
    checks++;
    if (obs !== 9'b0001_0_1_00_0) begin
      errors++; $display("FAIL single_release_hold: got %b expected %b", obs, 9'b0001_0_1_00_0);
    end
    cyc();
    checks++;
    if (obs !== 9'b0001_0_1_00_0) begin
      errors++; $display("FAIL single_release_wait: got %b expected %b", obs, 9'b0001_0_1_00_0);
    end
    bus.reqs = 4'b0000;
    cyc();
    checks++;
    if (obs !== 9'b0000_0_0_00_0) begin
      errors++; $display("FAIL single_drop: got %b expected %b", obs, 9'b0000_0_0_00_0);
    end
  endtask

  task automatic test_round_robin();
    logic [8:0] e;
    int g;
    do_reset();
    bus.reqs = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      g = k % N;
      cyc();
      e = {4'(1 << g), 1'b1, 1'b1, 2'(g), 1'b0};
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, obs, e);
      end
      bus.done = 1'b1;
      cyc();
      bus.done = 1'b0;
      bus.reqs = bus.reqs & ~(4'b0001 << g);
      e = {4'(1 << g), 1'b0, 1'b1, 2'(g), 1'b0};
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL rr_hold%0d: got %b expected %b", k, obs, e);
      end
      cyc();
      e = {4'b0000, 1'b0, 1'b0, 2'(g), 1'b0};
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL rr_release%0d: got %b expected %b", k, obs, e);
      end
      bus.reqs = 4'b1111;
    end
    bus.reqs = 4'b0000;
    cyc();
  endtask

  task automatic test_watchdog();
    logic [8:0] e;
    do_reset();
    bus.reqs = 4'b0100;
    cyc();
    checks++;
    if (obs !== 9'b0100_1_1_10_0) begin
      errors++; $display("FAIL wd_grant: got %b expected %b", obs, 9'b0100_1_1_10_0);
    end
    cyc();
    for (int i = 1; i <= TO; i++) begin
      cyc();
      e = {4'b0100, 1'b0, 1'b1, 2'd2, (i == TO)};
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL wd_wait%0d: got %b expected %b", i, obs, e);
      end
    end
    cyc();
    checks++;
    if (obs !== 9'b0100_0_1_10_0) begin
      errors++; $display("FAIL wd_hold: got %b expected %b", obs, 9'b0100_0_1_10_0);
    end
    bus.reqs = 4'b0000;
    cyc();
    checks++;
    if (obs !== 9'b0000_0_0_10_0) begin
      errors++; $display("FAIL wd_idle: got %b expected %b", obs, 9'b0000_0_0_10_0);
    end
  endtask

  task automatic test_collision();
    do_reset();
    bus.reqs = 4'b0001;
    cyc();
    cyc();
    for (int i = 0; i < TO - 1; i++) cyc();
    bus.done = 1'b1;
    cyc();
    bus.done = 1'b0;
    checks++;
    if (obs !== 9'b0001_0_1_00_0) begin
      errors++; $display("FAIL coll_no_err: got %b expected %b", obs, 9'b0001_0_1_00_0);
    end
    bus.reqs = 4'b0000;
    cyc();
    checks++;
    if (obs !== 9'b0000_0_0_00_0) begin
      errors++; $display("FAIL coll_release: got %b expected %b", obs, 9'b0000_0_0_00_0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.reqs = 4'b0010;
    cyc();
    cyc();
    cyc();
    checks++;
    if (obs !== 9'b0010_0_1_01_0) begin
      errors++; $display("FAIL rm_wait: got %b expected %b", obs, 9'b0010_0_1_01_0);
    end
    rst = 1'b1; bus.reqs = 4'b1010;
    cyc();
    rst = 1'b0;
    checks++;
    if (obs !== 9'b0000_0_0_00_0) begin
      errors++; $display("FAIL rm_reset: got %b expected %b", obs, 9'b0000_0_0_00_0);
    end
    cyc();
    checks++;
    if (obs !== 9'b0010_1_1_01_0) begin
      errors++; $display("FAIL rm_regrant: got %b expected %b", obs, 9'b0010_1_1_01_0);
    end
    do_reset();
  endtask

  task automatic test_early_drop();
    do_reset();
    bus.reqs = 4'b0010;
    cyc();
    cyc();
    bus.reqs = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (obs !== 9'b0010_0_1_01_0) begin
        errors++; $display("FAIL ed_hold%0d: got %b expected %b", i, obs, 9'b0010_0_1_01_0);
      end
    end
    bus.done = 1'b1;
    cyc();
    bus.done = 1'b0;
    checks++;
    if (obs !== 9'b0010_0_1_01_0) begin
      errors++; $display("FAIL ed_release: got %b expected %b", obs, 9'b0010_0_1_01_0);
    end
    cyc();
    checks++;
    if (obs !== 9'b0000_0_0_01_0) begin
      errors++; $display("FAIL ed_idle: got %b expected %b", obs, 9'b0000_0_0_01_0);
    end
    bus.done = 1'b1;
    cyc();
    bus.done = 1'b0;
    cyc();
    checks++;
    if (obs !== 9'b0000_0_0_01_0) begin
      errors++; $display("FAIL ed_stray_done: got %b expected %b", obs, 9'b0000_0_0_01_0);
    end
  endtask

  // Random requesters and done pulses against a transaction-level model:
  // the model tracks the current owner, the cycles elapsed since its grant
  // and whether its operation has finished, instead of arbiter states.
  task automatic test_random();
    int owner, ptr, last, age, c;
    bit fin, e_start, e_terr;
    logic [3:0] r, m, e_acks;
    logic d, rs;
    logic [8:0] e;
    do_reset();
    owner = -1; ptr = N - 1; last = 0; age = 0; fin = 1'b0;
    for (int cy = 0; cy < 2000; cy++) begin
      r = bus.reqs;
      for (int i = 0; i < N; i++) begin
        m = 4'b0001 << i;
        if ((r & m) != 4'b0000) begin
          if (owner == i && $urandom_range(3) == 0) r = r & ~m;
        end else if (owner != i && $urandom_range(2) == 0) begin
          r = r | m;
        end
      end
      d  = ($urandom_range(4) == 0);
      rs = ($urandom_range(149) == 0);
      rst = rs; bus.reqs = r; bus.done = d;

      e_start = 1'b0; e_terr = 1'b0;
      if (rs) begin
        owner = -1; ptr = N - 1; last = 0; age = 0; fin = 1'b0;
      end else if (owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          c = (ptr + k) % N;
          if (owner < 0 && (r & (4'b0001 << c)) != 4'b0000) owner = c;
        end
        if (owner >= 0) begin
          last = owner; age = 0; fin = 1'b0; e_start = 1'b1;
        end
      end else if (!fin) begin
        if (d) fin = 1'b1;
        else if (TO != 0 && age == TO) begin
          fin = 1'b1; e_terr = 1'b1;
        end
        age++;
      end else if ((r & (4'b0001 << owner)) == 4'b0000) begin
        ptr = owner; owner = -1;
      end

      cyc();
      e_acks = (owner >= 0) ? 4'(1 << owner) : 4'b0000;
      e = {e_acks, e_start, (owner >= 0), 2'(last), e_terr};
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL random_cy%0d: got %b expected %b", cy, obs, e);
      end
    end
    rst = 1'b0; bus.reqs = 4'b0000; bus.done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bus.reqs = 4'b0000; bus.done = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_watchdog();
    test_collision();
    test_reset_mid();
    test_early_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
